// File: rtl/xiphos_arb_pkg.sv
// Shared types and helpers for the register-write arbiter.
package xiphos_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Widest requester vector the onehot() helper can produce.
   localparam int MAX_REQ = 32;

   // Width of a requester index; never below one bit.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // One-hot vector with bit idx set; callers narrow it with a size cast.
   function automatic logic [MAX_REQ-1:0] onehot(input int idx);
      logic [MAX_REQ-1:0] one;
      one = {{(MAX_REQ-1){1'b0}}, 1'b1};
      return one << idx;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set candidate at or after ptr_i.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] cand_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [PTR_W-1:0] winner_o,
   output logic             valid_o
);

   logic [2*N_REQ-1:0] cand_dbl;
   logic [N_REQ-1:0]   cand_rot;
   int                 idx;

   // Rotate candidates so ptr_i sits at bit 0, then take the lowest set bit.
   always_comb begin
      cand_dbl = {cand_i, cand_i};
      cand_rot = N_REQ'(cand_dbl >> ptr_i);
      winner_o = '0;
      valid_o  = 1'b0;
      idx      = 0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!valid_o && cand_rot[k]) begin
            valid_o = 1'b1;
            idx     = int'(ptr_i) + k;
            if (idx >= N_REQ) begin
               idx = idx - N_REQ;
            end
            winner_o = PTR_W'(idx);
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one registered register-bank write port.
//
// state | meaning
// IDLE  | no grant outstanding, waiting for any request
// GRANT | gnt_q holds the current owner; transfers happen when it requests
module reg_write_arbiter
   import xiphos_arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int MAX_LOCK = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          req_lock,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          gnt,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [DATA_W-1:0]         wr_data,
   output logic                      busy
);

   localparam int PTR_W  = ptr_width(N_REQ);
   localparam int LCNT_W = $clog2(MAX_LOCK + 1);

   arb_state_e         state_q,    state_d;
   logic [N_REQ-1:0]   gnt_q,      gnt_d;
   logic [PTR_W-1:0]   owner_q,    owner_d;
   logic [PTR_W-1:0]   rr_ptr_q,   rr_ptr_d;
   logic [LCNT_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic               wr_en_q,    wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q,  wr_addr_d;
   logic [DATA_W-1:0]  wr_data_q,  wr_data_d;

   logic [ADDR_W-1:0]  addr_arr [N_REQ];
   logic [DATA_W-1:0]  data_arr [N_REQ];
   logic [N_REQ-1:0]   owner_oh;
   logic [PTR_W-1:0]   owner_next;
   logic               transfer;
   logic               lock_keep;

   logic [N_REQ-1:0]   pick_cand;
   logic [PTR_W-1:0]   pick_ptr;
   logic [PTR_W-1:0]   pick_win;
   logic               pick_valid;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .cand_i   (pick_cand),
      .ptr_i    (pick_ptr),
      .winner_o (pick_win),
      .valid_o  (pick_valid)
   );

   // Unpack per-requester address/data and derive owner-related terms.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
         data_arr[i] = req_data[i*DATA_W +: DATA_W];
      end
      owner_oh   = N_REQ'(onehot(int'(owner_q)));
      owner_next = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
      transfer   = |(gnt_q & req);
      lock_keep  = req[owner_q] && req_lock[owner_q]
                   && ((int'(lock_cnt_q) + 1) < MAX_LOCK);
   end

   // Picker inputs: raw requests from rr_ptr in IDLE, others-only after the owner on release.
   always_comb begin
      pick_cand = req;
      pick_ptr  = rr_ptr_q;
      if (state_q == GRANT) begin
         pick_cand = req & ~owner_oh;
         pick_ptr  = owner_next;
      end
   end

   // Next-state, grant and write-port logic.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      lock_cnt_d = lock_cnt_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      if (transfer) begin
         wr_en_d   = 1'b1;
         wr_addr_d = addr_arr[owner_q];
         wr_data_d = data_arr[owner_q];
      end

      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (pick_valid) begin
               gnt_d      = N_REQ'(onehot(int'(pick_win)));
               owner_d    = pick_win;
               lock_cnt_d = '0;
               state_d    = GRANT;
            end
         end
         GRANT: begin
            if (lock_keep) begin
               lock_cnt_d = lock_cnt_q + LCNT_W'(1);
            end else begin
               rr_ptr_d   = owner_next;
               lock_cnt_d = '0;
               if (pick_valid) begin
                  gnt_d   = N_REQ'(onehot(int'(pick_win)));
                  owner_d = pick_win;
               end else begin
                  gnt_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset wins over any same-cycle transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         lock_cnt_q <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_cnt_q <= lock_cnt_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign gnt     = gnt_q;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = (state_q == GRANT);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter (4 requesters, MAX_LOCK=3).
module tb_reg_write_arbiter;

   localparam int N  = 4;
   localparam int AW = 3;
   localparam int DW = 8;
   localparam int ML = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N-1:0]    req_lock;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    gnt;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic            busy;

   reg_write_arbiter #(
      .N_REQ    (N),
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .MAX_LOCK (ML)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_lock (req_lock),
      .req_addr (req_addr),
      .req_data (req_data),
      .gnt      (gnt),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          en;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      logic         rst;
      logic         pin;
      logic [N-1:0] req;
      logic [N-1:0] lock;
      logic [N-1:0] gnt;
      logic         busy;
   } vec_t;

   wr_t           exp_q[$];
   vec_t          vecs[$];
   int            checks = 0;
   int            errors = 0;
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_data;
   logic [AW-1:0] a_v [N];
   logic [DW-1:0] d_v [N];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic p, input logic [N-1:0] rq,
                      input logic [N-1:0] lk, input logic [N-1:0] g, input logic b);
      vec_t v;
      v.rst = r; v.pin = p; v.req = rq; v.lock = lk; v.gnt = g; v.busy = b;
      vecs.push_back(v);
   endtask

   // One cycle: drive inputs, check the registered outputs, predict next write port.
   task automatic cycle(input vec_t v, input int step);
      wr_t e;
      int  w;
      for (int i = 0; i < N; i++) begin
         a_v[i] = AW'($urandom_range(0, (1 << AW) - 1));
         d_v[i] = DW'($urandom_range(0, (1 << DW) - 1));
      end
      if (v.pin) begin
         a_v[2] = 3'd5;
         d_v[2] = 8'hA5;
      end
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW] = a_v[i];
         req_data[i*DW +: DW] = d_v[i];
      end
      rst      = v.rst;
      req      = v.req;
      req_lock = v.lock;
      #1;
      check($sformatf("gnt@%0d", step), 32'(gnt), 32'(v.gnt));
      check($sformatf("busy@%0d", step), 32'(busy), 32'(v.busy));
      check($sformatf("gnt_onehot0@%0d", step), 32'($onehot0(gnt)), 32'd1);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty@%0d got 0 entries expected 1", step);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("wr_en@%0d", step), 32'(wr_en), 32'(e.en));
         check($sformatf("wr_addr@%0d", step), 32'(wr_addr), 32'(e.addr));
         check($sformatf("wr_data@%0d", step), 32'(wr_data), 32'(e.data));
      end
      if (v.rst) begin
         last_addr = '0;
         last_data = '0;
         exp_q.push_back('{1'b0, AW'(0), DW'(0)});
      end else if (|(v.gnt & v.req)) begin
         w = 0;
         for (int i = 0; i < N; i++) begin
            if (v.gnt[i]) w = i;
         end
         last_addr = a_v[w];
         last_data = d_v[w];
         exp_q.push_back('{1'b1, a_v[w], d_v[w]});
      end else begin
         exp_q.push_back('{1'b0, last_addr, last_data});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t h;
      //   rst   pin   req      lock     gnt      busy
      // single request from requester 2
      add(1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      add(1'b0, 1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b1);
      add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      // reset, then fairness with all four requesting
      add(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      add(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b1);
      add(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0010, 1'b1);
      add(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0100, 1'b1);
      add(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b1000, 1'b1);
      add(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b1);
      add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b1);
      add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      // lock cap: requester 0 locked, requester 1 waiting
      add(1'b0, 1'b0, 4'b0011, 4'b0001, 4'b0000, 1'b0);
      add(1'b0, 1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b1);
      add(1'b0, 1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b1);
      add(1'b0, 1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b1);
      add(1'b0, 1'b0, 4'b0011, 4'b0001, 4'b0010, 1'b1);
      add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b1);
      add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      // abandon by requester 2, then wrap 3 -> 0
      add(1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      add(1'b0, 1'b0, 4'b1000, 4'b0000, 4'b0100, 1'b1);
      add(1'b0, 1'b0, 4'b1001, 4'b0000, 4'b1000, 1'b1);
      add(1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1);
      add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      // pointer now 1: all requesting picks requester 1
      add(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b1);
      add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      // reset in the middle of a locked burst by requester 1
      add(1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b0);
      add(1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b1);
      add(1'b1, 1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b1);
      add(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b1);
      add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);

      rst       = 1'b1;
      req       = '0;
      req_lock  = '0;
      req_addr  = '0;
      req_data  = '0;
      last_addr = '0;
      last_data = '0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back('{1'b0, AW'(0), DW'(0)});

      for (int s = 0; s < vecs.size(); s++) begin
         cycle(vecs[s], s);
      end

      // Lone locked requester hits the cap: one idle cycle, then it wins again.
      h.rst = 1'b0; h.pin = 1'b0;
      h.req = 4'b0001; h.lock = 4'b0001; h.gnt = 4'b0000; h.busy = 1'b0; cycle(h, 100);
      h.gnt = 4'b0001; h.busy = 1'b1;                                    cycle(h, 101);
      cycle(h, 102);
      cycle(h, 103);
      h.gnt = 4'b0000; h.busy = 1'b0;                                    cycle(h, 104);
      h.req = 4'b0000; h.lock = 4'b0000; h.gnt = 4'b0001; h.busy = 1'b1; cycle(h, 105);
      h.gnt = 4'b0000; h.busy = 1'b0;                                    cycle(h, 106);
      cycle(h, 107);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares one register-bank write port (the DFF-based state array) among N_REQ requesters.
- Uses a req/gnt handshake; winners come from a rotating pointer.
- Optional lock lets one requester perform back-to-back writes, capped at MAX_LOCK.
- The write port is fully registered and drives the register bank's write-enable, address and data inputs directly.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- DATA_W, 8, write data width.
- ADDR_W, 3, register address width.
- MAX_LOCK, 8, maximum consecutive transfers by one locked owner (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request, held until granted.
- req_lock  in  N_REQ  per-requester "keep grant after this transfer".
- req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_data  in  N_REQ*DATA_W  packed data, same packing rule.
- gnt  out  N_REQ  one-hot or zero grant, registered.
- wr_en  out  1  register-bank write enable, registered.
- wr_addr  out  ADDR_W  register-bank write address, registered.
- wr_data  out  DATA_W  register-bank write data, registered.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (rst high at an edge): state=IDLE, rr_ptr=0, lock_cnt=0, gnt=0, wr_en=0, wr_addr=0, wr_data=0, busy=0. Reset overrides every other event in the same cycle. A transfer handshaking in that cycle is dropped and never written.
- Round-robin pick (used below): first index j in rr_ptr, rr_ptr+1, ... (mod N_REQ) with cand[j]=1.
- Transfer: occurs in any cycle where gnt[i] & req[i].
- Write port: next edge sets wr_en=1, wr_addr=req_addr[i], wr_data=req_data[i]. Otherwise wr_en=0 and wr_addr/wr_data hold their value.
- Latency: request seen in IDLE at cycle t -> gnt at t+1 -> transfer at t+1 -> wr_en at t+2.
- State IDLE:
  - gnt=0.
  - If |req: pick with cand=req, gnt<=onehot(winner), lock_cnt<=0, go GRANT.
  - Else stay IDLE.
- State GRANT, owner i:
  - Continue: req[i] & req_lock[i] & (lock_cnt+1 < MAX_LOCK) -> transfer, lock_cnt++, keep owner.
  - Release: any other case. Covers transfer without lock, lock_cnt limit reached, or req[i]=0 (abandon, no transfer, no write). Effects:
    - rr_ptr <= (i+1) mod N_REQ.
    - lock_cnt <= 0.
    - cand = req & ~onehot(i), picked from (i+1) mod N_REQ.
    - If |cand: gnt<=onehot(winner), stay GRANT (no bubble).
    - Else gnt<=0, go IDLE.
- Forced release at MAX_LOCK: owner may re-win only after every other pending requester has been served once.
- Invariants:
  - gnt never has more than one bit set.
  - gnt changes only on clock edges.
  - req_addr and req_data are sampled only in transfer cycles.
- MAX_LOCK=1: lock has no effect.
- Pointer wraps from N_REQ-1 to 0.

Decomposition:
- Package xiphos_arb_pkg:
  - state enum {IDLE, GRANT}.
  - Pointer-width helper $clog2(N_REQ).
  - onehot() function.
- Sub-module rr_pick (combinational): inputs cand[N_REQ] and ptr; outputs winner index and valid. Instantiated once; the arbiter drives cand with either req or the masked req.

Test Plan:
- Single request: after reset, req=4'b0100, addr=5, data=8'hA5 held at cycle 1.
  -> gnt=4'b0100 at cycle 2.
  -> wr_en=1, wr_addr=5, wr_data=A5 at cycle 3.
  -> req dropped, gnt=0 and busy=0 at cycle 3.
- Fairness: all four req held continuously, no lock.
  -> gnt order 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
  -> wr_en high every cycle from cycle 3.
- Lock cap: MAX_LOCK=3, req0 with lock held, req1 held.
  -> requester 0 gets 3 transfers.
  -> then gnt=0010 for one transfer.
  -> then gnt=0001 again.
- Abandon: grant to requester 2, req[2] deasserted the same cycle, req3 pending.
  -> no wr_en for 2.
  -> gnt=1000 next cycle, rr_ptr=3.
- Wrap: requesters 3 and 0 pending, rr_ptr=3.
  -> gnt 1000 then 0001.
  -> rr_ptr returns to 1 after the second release.
- Reset mid-burst: rst high during a locked transfer.
  -> next edge: gnt=0, wr_en=0, busy=0, wr_addr=0, wr_data=0.
  -> the in-flight write never appears.
  -> after rst falls, arbitration restarts from rr_ptr=0.
